// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the two-port data-memory arbiter.
//   state_t      : arbiter sequencer states (IDLE -> ISSUE -> RESP -> IDLE)
//   DEF_ADDR_W   : default address width (memory depth 2**DEF_ADDR_W)
//   DEF_DATA_W   : default data width
//   PORT_CORE    : port index of the core load/store stage
//   PORT_DBG     : port index of the debug/DMA loader
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way picker used by dmem_arbiter while it sits in IDLE.
//   req[1:0]    in   pending requests (bit 0 = core port, bit 1 = debug port)
//   last_grant  in   port that completed the previous transaction
//   winner      out  selected port index (only meaningful when |req)
//
// Build option:
//   DMEM_ARB_FIXED_PRIO_EN  defined   -> port 0 always wins contention and
//                                        last_grant is ignored (port 1 may starve)
//                           undefined -> round-robin on contention
// -----------------------------------------------------------------------------
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       winner
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
    // last_grant is intentionally ignored in fixed-priority builds.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        winner = PORT_CORE;
        if (!req[0] && req[1]) begin
            winner = PORT_DBG;
        end
    end
`else
    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the case leaves it unassigned (no latch).
        winner = PORT_CORE;
        case (req)
            2'b10:   winner = PORT_DBG;
            // Contention: hand the grant to whoever did not go last.
            2'b11:   winner = ~last_grant;
            default: winner = PORT_CORE;
        endcase
    end
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Arbiter and sequencer in front of the 256x8 data memory. The memory acts on
// the falling clock edge and has a registered read port, so one access takes
// a single ISSUE cycle: enables are held for the full cycle, the memory
// samples them mid-cycle, and read data is captured at the closing rising edge.
//
// Ports:
//   CLK, RST               clock (rising edge), async active-low reset
//   req0/1, we0/1          request and write-select per port (0 core, 1 debug)
//   addr0/1, wdata0/1      request address / write data per port
//   ack0/1                 one-cycle completion pulse to the winner
//   rdata0/1               read data, valid with ack and held afterwards
//   mem_write_en/read_en   memory enables, one cycle, never both high
//   mem_addr, mem_wdata    latched address / write data to the memory
//   mem_rd                 registered read data from the memory
//   busy                   high while in ISSUE or RESP
//   gnt_id                 port owning the current or last transaction
//
// Build option DMEM_ARB_FIXED_PRIO_EN selects fixed priority (see rr_arb2).
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_write_en,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rd,
    output logic              busy,
    output logic              gnt_id
);

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                gnt_id_q, gnt_id_d;
    logic                mem_write_en_q, mem_write_en_d;
    logic                mem_read_en_q, mem_read_en_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic [DATA_W-1:0]   rdata0_q, rdata0_d;
    logic [DATA_W-1:0]   rdata1_q, rdata1_d;
    logic                busy_q, busy_d;

    logic                winner;
    logic                win_we;

    rr_arb2 u_rr_arb2 (
        .req        ({req1, req0}),
        .last_grant (last_grant_q),
        .winner     (winner)
    );

    assign win_we = (winner == PORT_DBG) ? we1 : we0;

    always_comb begin
        state_d        = state_q;
        last_grant_d   = last_grant_q;
        gnt_id_d       = gnt_id_q;
        mem_write_en_d = mem_write_en_q;
        mem_read_en_d  = mem_read_en_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        rdata0_d       = rdata0_q;
        rdata1_d       = rdata1_q;
        // Acks are pulses: low unless the ISSUE cycle is closing.
        ack0_d         = 1'b0;
        ack1_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_id_d       = winner;
                    mem_write_en_d = win_we;
                    mem_read_en_d  = !win_we;
                    mem_addr_d     = (winner == PORT_DBG) ? addr1  : addr0;
                    mem_wdata_d    = (winner == PORT_DBG) ? wdata1 : wdata0;
                    state_d        = ISSUE;
                end
            end

            ISSUE: begin
                // The memory acted on the mid-cycle falling edge; mem_rd now
                // holds the registered read result.
                mem_write_en_d = 1'b0;
                mem_read_en_d  = 1'b0;
                ack0_d         = (gnt_id_q == PORT_CORE);
                ack1_d         = (gnt_id_q == PORT_DBG);
                if (mem_read_en_q) begin
                    if (gnt_id_q == PORT_DBG) begin
                        rdata1_d = mem_rd;
                    end else begin
                        rdata0_d = mem_rd;
                    end
                end
                state_d = RESP;
            end

            RESP: begin
                // Requester drops req at the edge ending this cycle, so the
                // next IDLE only sees genuinely new requests.
                last_grant_d = gnt_id_q;
                state_d      = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q        <= IDLE;
            // Port 0 wins the first contention after reset.
            last_grant_q   <= PORT_DBG;
            gnt_id_q       <= PORT_CORE;
            mem_write_en_q <= 1'b0;
            mem_read_en_q  <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            ack0_q         <= 1'b0;
            ack1_q         <= 1'b0;
            rdata0_q       <= '0;
            rdata1_q       <= '0;
            busy_q         <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values of the others.
            state_q        <= state_d;
            last_grant_q   <= last_grant_d;
            gnt_id_q       <= gnt_id_d;
            mem_write_en_q <= mem_write_en_d;
            mem_read_en_q  <= mem_read_en_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            ack0_q         <= ack0_d;
            ack1_q         <= ack1_d;
            rdata0_q       <= rdata0_d;
            rdata1_q       <= rdata1_d;
            busy_q         <= busy_d;
        end
    end

    assign ack0         = ack0_q;
    assign ack1         = ack1_q;
    assign rdata0       = rdata0_q;
    assign rdata1       = rdata1_q;
    assign mem_write_en = mem_write_en_q;
    assign mem_read_en  = mem_read_en_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign busy         = busy_q;
    assign gnt_id       = gnt_id_q;

endmodule
